// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and constants for the two-master bus arbiter:
//               FSM state encoding, transfer mode codes, master count and a
//               helper that flags reserved transfer modes.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  localparam int NUM_MASTERS = 2;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Any mode with the upper bit set (2'b10, 2'b11) is reserved.
  function automatic logic mode_reserved(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational 2-way round-robin picker. When both masters
//               request, the one that did not own the bus last time wins;
//               a lone requester always wins.
// Ports       : req        in  [1:0] request vector, bit i = master i
//               last_owner in        index of the previous grant holder
//               winner     out       index of the selected master
//               valid      out       high when any master is requesting
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last_owner,
  output logic                   winner,
  output logic                   valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter granting one of two masters access to a
//               single shared target. A granted master issues one transfer
//               (read/write); the arbiter forwards it to the target, waits
//               for completion or a timeout, then returns to IDLE.
// Ports       : clk, rst               clock, synchronous active-high reset
//               m_req[1:0]             per-master bus request
//               m_start[1:0]           per-master transfer start
//               m_mode0/1[1:0]         transfer mode (00 rd, 01 wr, 1x rsvd)
//               m_addr0/1[7:0]         transfer address
//               m_wdata0/1[7:0]        write data
//               m_gnt[1:0]             one-hot-or-zero grant
//               m_rdy[1:0]             one-cycle completion pulse
//               m_err[1:0]             one-cycle error pulse
//               m_rdata[7:0]           read data, valid with m_rdy
//               s_start                one-cycle start pulse to target
//               s_mode/s_addr/s_wdata  registered transfer fields
//               s_rdy, s_rdata[7:0]    target completion and read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_start,
  input  logic [1:0]             m_mode0,
  input  logic [1:0]             m_mode1,
  input  logic [7:0]             m_addr0,
  input  logic [7:0]             m_addr1,
  input  logic [7:0]             m_wdata0,
  input  logic [7:0]             m_wdata1,
  output logic [NUM_MASTERS-1:0] m_gnt,
  output logic [NUM_MASTERS-1:0] m_rdy,
  output logic [NUM_MASTERS-1:0] m_err,
  output logic [7:0]             m_rdata,
  output logic                   s_start,
  output logic [1:0]             s_mode,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  input  logic                   s_rdy,
  input  logic [7:0]             s_rdata
);

  localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT);

  state_t                   state, state_d;
  logic                     last_owner, last_owner_d;
  logic [3:0]               wait_cnt, wait_cnt_d;
  logic [NUM_MASTERS-1:0]   gnt_d, rdy_d, err_d;
  logic [7:0]               rdata_d;
  logic                     s_start_d;
  logic [1:0]               s_mode_d;
  logic [7:0]               s_addr_d, s_wdata_d;

  logic                     pick_winner, pick_valid;
  logic                     sel_start, sel_req;
  logic [1:0]               sel_mode;
  logic [7:0]               sel_addr, sel_wdata;
  logic [4:0]               wait_inc;

  rr_pick u_pick (
    .req        (m_req),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // last_owner is updated on every grant, so while a grant is held it is
  // also the index of the current owner.
  always_comb begin
    sel_start = m_start[last_owner];
    sel_req   = m_req[last_owner];
    sel_mode  = last_owner ? m_mode1  : m_mode0;
    sel_addr  = last_owner ? m_addr1  : m_addr0;
    sel_wdata = last_owner ? m_wdata1 : m_wdata0;
    wait_inc  = {1'b0, wait_cnt} + 5'd1;
  end

  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    wait_cnt_d   = wait_cnt;
    gnt_d        = m_gnt;
    rdy_d        = '0;
    err_d        = '0;
    rdata_d      = m_rdata;
    s_start_d    = 1'b0;
    s_mode_d     = s_mode;
    s_addr_d     = s_addr;
    s_wdata_d    = s_wdata;

    case (state)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d              = '0;
          gnt_d[pick_winner] = 1'b1;
          last_owner_d       = pick_winner;
          state_d            = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (sel_start) begin
          if (mode_reserved(sel_mode)) begin
            err_d[last_owner] = 1'b1;
            gnt_d             = '0;
            state_d           = ST_IDLE;
          end else begin
            s_mode_d   = sel_mode;
            s_addr_d   = sel_addr;
            s_wdata_d  = sel_wdata;
            s_start_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_BUSY;
          end
        end else if (!sel_req) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // Completion has priority over a timeout landing in the same cycle.
        if (s_rdy) begin
          rdy_d[last_owner] = 1'b1;
          rdata_d           = s_rdata;
          gnt_d             = '0;
          state_d           = ST_IDLE;
        end else if (wait_inc >= TIMEOUT_LIM) begin
          err_d[last_owner] = 1'b1;
          gnt_d             = '0;
          state_d           = ST_IDLE;
        end else begin
          wait_cnt_d = wait_inc[3:0];
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      wait_cnt   <= '0;
      m_gnt      <= '0;
      m_rdy      <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      s_start    <= 1'b0;
      s_mode     <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
    end else begin
      state      <= state_d;
      last_owner <= last_owner_d;
      wait_cnt   <= wait_cnt_d;
      m_gnt      <= gnt_d;
      m_rdy      <= rdy_d;
      m_err      <= err_d;
      m_rdata    <= rdata_d;
      s_start    <= s_start_d;
      s_mode     <= s_mode_d;
      s_addr     <= s_addr_d;
      s_wdata    <= s_wdata_d;
    end
  end

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Directed scenarios plus
//               randomized traffic, compared every cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] m_req, m_start, m_mode0, m_mode1;
  logic [7:0] m_addr0, m_addr1, m_wdata0, m_wdata1;
  logic [1:0] m_gnt, m_rdy, m_err;
  logic [7:0] m_rdata;
  logic       s_start;
  logic [1:0] s_mode;
  logic [7:0] s_addr, s_wdata;
  logic       s_rdy;
  logic [7:0] s_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_start  (m_start),
    .m_mode0  (m_mode0),
    .m_mode1  (m_mode1),
    .m_addr0  (m_addr0),
    .m_addr1  (m_addr1),
    .m_wdata0 (m_wdata0),
    .m_wdata1 (m_wdata1),
    .m_gnt    (m_gnt),
    .m_rdy    (m_rdy),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_start  (s_start),
    .s_mode   (s_mode),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdy    (s_rdy),
    .s_rdata  (s_rdata)
  );

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ------------------------------------------------------- reference model
  // Tracks the bus as a transaction: who owns it (-1 = nobody), whether the
  // owner's transfer has been issued, and how many cycles it has waited.
  int         owner;
  bit         issued;
  int         waited;
  int         prev_owner;
  logic [1:0] exp_gnt, exp_rdy, exp_err, exp_smode;
  logic [7:0] exp_rdata, exp_saddr, exp_swdata;
  logic       exp_sstart;

  task automatic model_step();
    int         w;
    logic [1:0] md;
    exp_rdy    = 2'b00;
    exp_err    = 2'b00;
    exp_sstart = 1'b0;
    if (rst) begin
      owner = -1; issued = 0; waited = 0; prev_owner = 1;
      exp_rdata = 0; exp_smode = 0; exp_saddr = 0; exp_swdata = 0;
    end else if (owner < 0) begin
      if (m_req != 2'b00) begin
        if (m_req == 2'b11) w = 1 - prev_owner;
        else                w = m_req[1] ? 1 : 0;
        owner = w; prev_owner = w; issued = 0;
      end
    end else if (!issued) begin
      if (m_start[owner]) begin
        md = (owner == 1) ? m_mode1 : m_mode0;
        if (md >= 2) begin
          exp_err[owner] = 1'b1;
          owner = -1;
        end else begin
          exp_smode  = md;
          exp_saddr  = (owner == 1) ? m_addr1  : m_addr0;
          exp_swdata = (owner == 1) ? m_wdata1 : m_wdata0;
          exp_sstart = 1'b1;
          issued = 1; waited = 0;
        end
      end else if (!m_req[owner]) begin
        owner = -1;
      end
    end else begin
      waited++;
      if (s_rdy) begin
        exp_rdy[owner] = 1'b1;
        exp_rdata = s_rdata;
        owner = -1;
      end else if (waited >= TIMEOUT) begin
        exp_err[owner] = 1'b1;
        owner = -1;
      end
    end
    exp_gnt = 2'b00;
    if (owner >= 0) exp_gnt[owner] = 1'b1;
  endtask

  task automatic compare_all();
    check("m_gnt",   {30'd0, m_gnt},   {30'd0, exp_gnt});
    check("m_rdy",   {30'd0, m_rdy},   {30'd0, exp_rdy});
    check("m_err",   {30'd0, m_err},   {30'd0, exp_err});
    check("m_rdata", {24'd0, m_rdata}, {24'd0, exp_rdata});
    check("s_start", {31'd0, s_start}, {31'd0, exp_sstart});
    check("s_mode",  {30'd0, s_mode},  {30'd0, exp_smode});
    check("s_addr",  {24'd0, s_addr},  {24'd0, exp_saddr});
    check("s_wdata", {24'd0, s_wdata}, {24'd0, exp_swdata});
    check("rdy_err_excl", {31'd0, (|m_rdy) & (|m_err)}, 32'd0);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs are
  // compared 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    m_req = 0; m_start = 0; m_mode0 = 0; m_mode1 = 0;
    m_addr0 = 0; m_addr1 = 0; m_wdata0 = 0; m_wdata1 = 0;
    s_rdy = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Grant master `mi` alone, then issue a transfer with the given mode.
  task automatic grant_and_start(input int mi, input logic [1:0] md,
                                 input logic [7:0] addr, input logic [7:0] wd);
    idle_inputs();
    m_req[mi] = 1'b1;
    cycle();
    m_start[mi] = 1'b1;
    if (mi == 1) begin m_mode1 = md; m_addr1 = addr; m_wdata1 = wd; end
    else         begin m_mode0 = md; m_addr0 = addr; m_wdata0 = wd; end
    cycle();
    m_start = 0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [1:0] seen_gnt [3];
    rst = 1'b1;
    idle_inputs();
    m_req = 2'b11; m_start = 2'b11; s_rdy = 1'b1; s_rdata = 8'hFF;
    do_reset();
    check("reset_gnt",   {30'd0, m_gnt}, 32'd0);
    check("reset_sstart", {31'd0, s_start}, 32'd0);
    idle_inputs();

    // Single read by master 0.
    idle_inputs();
    m_req = 2'b01;
    cycle();
    check("rd_gnt", {30'd0, m_gnt}, 32'h1);
    m_start = 2'b01; m_mode0 = 2'b00; m_addr0 = 8'h3C;
    cycle();
    check("rd_saddr", {24'd0, s_addr}, 32'h3C);
    check("rd_sstart", {31'd0, s_start}, 32'h1);
    m_start = 0;
    cycle();
    s_rdy = 1'b1; s_rdata = 8'hA5;
    cycle();
    check("rd_mrdy", {30'd0, m_rdy}, 32'h1);
    check("rd_mrdata", {24'd0, m_rdata}, 32'hA5);
    idle_inputs();
    cycle();

    // Round-robin under continuous contention.
    do_reset();
    idle_inputs();
    m_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cycle();
      seen_gnt[k] = m_gnt;
      m_start = m_gnt;
      cycle();
      m_start = 0; s_rdy = 1'b1; s_rdata = 8'(k);
      cycle();
      s_rdy = 1'b0;
    end
    check("rr_gnt0", {30'd0, seen_gnt[0]}, 32'h1);
    check("rr_gnt1", {30'd0, seen_gnt[1]}, 32'h2);
    check("rr_gnt2", {30'd0, seen_gnt[2]}, 32'h1);
    idle_inputs();
    cycle();

    // Reserved mode.
    grant_and_start(0, 2'b10, 8'h11, 8'h22);
    check("rsv_err", {30'd0, m_err}, 32'h1);
    check("rsv_sstart", {31'd0, s_start}, 32'h0);
    check("rsv_gnt", {30'd0, m_gnt}, 32'h0);
    idle_inputs();
    cycle();

    // Timeout with s_rdy held low.
    grant_and_start(1, 2'b01, 8'h40, 8'h5A);
    idle_inputs();
    m_req = 2'b10;
    for (int k = 1; k < TIMEOUT; k++) cycle();
    check("to_noerr_early", {30'd0, m_err}, 32'h0);
    cycle();
    check("to_err", {30'd0, m_err}, 32'h2);
    check("to_gnt", {30'd0, m_gnt}, 32'h0);
    idle_inputs();
    cycle();

    // s_rdy on the timeout cycle wins.
    grant_and_start(1, 2'b00, 8'h41, 8'h00);
    idle_inputs();
    m_req = 2'b10;
    for (int k = 1; k < TIMEOUT; k++) cycle();
    s_rdy = 1'b1; s_rdata = 8'hC3;
    cycle();
    check("to_edge_rdy", {30'd0, m_rdy}, 32'h2);
    check("to_edge_err", {30'd0, m_err}, 32'h0);
    idle_inputs();
    cycle();

    // Reset during BUSY, then a stale s_rdy.
    grant_and_start(0, 2'b01, 8'h77, 8'h88);
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s_rdy = 1'b1; s_rdata = 8'h99;
    cycle();
    check("rst_busy_rdy", {30'd0, m_rdy}, 32'h0);
    check("rst_busy_addr", {24'd0, s_addr}, 32'h0);
    idle_inputs();

    // Start from the non-granted master.
    m_req = 2'b01;
    cycle();
    m_start = 2'b10; m_mode1 = 2'b00;
    cycle();
    check("ng_sstart", {31'd0, s_start}, 32'h0);
    idle_inputs();
    cycle();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      m_req    = 2'($urandom);
      m_start  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      m_mode0  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      m_mode1  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      m_addr0  = 8'($urandom);
      m_addr1  = 8'($urandom);
      m_wdata0 = 8'($urandom);
      m_wdata1 = 8'($urandom);
      s_rdy    = ($urandom_range(0, 7) == 0);
      s_rdata  = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bus_arbiter
`default_nettype wire
